// File: rtl/dac8728_pkg.sv
// Shared definitions for the DAC8728 channel scheduler and its write wrapper.
package dac8728_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Channel index width; covers up to 8 channels.
  localparam int CH_W = 3;

  localparam int         DEF_NUM_CH    = 8;
  localparam logic [4:0] DEF_ADDR_BASE = 5'd8;

endpackage

// File: rtl/dac8728_scheduler_rr_pick.sv
// Round-robin first-set search: returns the first dirty channel at or after
// ptr, wrapping at N. ptr is always kept below N by the caller.
module rr_pick
  import dac8728_pkg::*;
#(
  parameter int N = DEF_NUM_CH
) (
  input  logic [N-1:0]      dirty,
  input  logic [CH_W-1:0]   ptr,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  logic [CH_W:0] c;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = '0;
    for (int i = 0; i < N; i++) begin
      c = {1'b0, ptr} + (CH_W+1)'(i);
      if (c >= (CH_W+1)'(N)) c = c - (CH_W+1)'(N);
      if (!found && dirty[c[CH_W-1:0]]) begin
        found = 1'b1;
        idx   = c[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dac8728_scheduler.sv
// Channel scheduler in front of the single-stream DAC8728 write wrapper.
// Holds a setpoint table with dirty bits, serves dirty channels round-robin,
// presents one address/data pair at a time until done_dac confirms it.
// Optional periodic refresh re-marks every channel dirty; a watchdog flags
// a wrapper that never answers.
module dac8728_scheduler
  import dac8728_pkg::*;
#(
  parameter int          NUM_CH      = DEF_NUM_CH,
  parameter logic [4:0]  ADDR_BASE   = DEF_ADDR_BASE,
  parameter logic [31:0] REFRESH_CYC = 32'd100000,
  parameter logic [31:0] TIMEOUT     = 32'd4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [2:0]         wr_ch,
  input  logic signed [15:0] wr_data,
  input  logic               refresh_en,
  input  logic               fault_clr,
  input  logic               done_dac,
  output logic [4:0]         dac_add_in,
  output logic signed [15:0] dac_data_in,
  output logic               ch_done,
  output logic [2:0]         ch_done_id,
  output logic [NUM_CH-1:0]  pending,
  output logic               busy,
  output logic               fault
);

  // Address map must fit the 5-bit register space.
  if (int'(ADDR_BASE) + NUM_CH - 1 > 31 || NUM_CH < 1 || NUM_CH > 8 ||
      REFRESH_CYC < 32'd2) begin : g_bad_cfg
    $error("dac8728_scheduler: invalid NUM_CH/ADDR_BASE/REFRESH_CYC");
  end

  state_t             state, state_nxt;
  logic signed [15:0] tbl [NUM_CH];
  logic [NUM_CH-1:0]  dirty, dirty_nxt;
  logic [CH_W-1:0]    rr_ptr, cur_ch, pick_idx;
  logic               pick_found;
  logic [31:0]        ref_cnt, wd_cnt;
  logic               wr_ok, ref_hit, wd_hit, load_go, done_go;

  assign wr_ok   = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));
  assign ref_hit = refresh_en && (ref_cnt == REFRESH_CYC - 32'd1);
  assign wd_hit  = (state == WAIT) && (wd_cnt == TIMEOUT - 32'd1);
  assign pending = dirty;

  rr_pick #(.N(NUM_CH)) u_pick (
    .dirty (dirty),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|dirty) state_nxt = LOAD;
      LOAD:    state_nxt = pick_found ? WAIT : IDLE;
      WAIT:    if (done_dac) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM decoded strobes; done_dac only counts while a pair is presented.
  always_comb begin
    load_go = (state == LOAD) && pick_found;
    done_go = (state == WAIT) && done_dac;
    busy    = (state != IDLE);
  end

  // Dirty update: LOAD clears the picked bit, a host write then re-sets it
  // (so a write racing the LOAD wins), refresh sets everything.
  always_comb begin
    dirty_nxt = dirty;
    if (load_go) dirty_nxt[pick_idx] = 1'b0;
    if (wr_ok)   dirty_nxt[wr_ch]    = 1'b1;
    if (ref_hit) dirty_nxt           = '1;
  end

  // Dirty bits come out of reset all set so every channel is driven to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dirty <= '1;
    else     dirty <= dirty_nxt;
  end

  // Setpoint table; a write in the LOAD cycle lands after the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) tbl[i] <= '0;
    end else if (wr_ok) begin
      tbl[wr_ch] <= wr_data;
    end
  end

  // Presented pair only changes on the LOAD exit edge; confirm on done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_add_in  <= ADDR_BASE;
      dac_data_in <= '0;
      ch_done     <= 1'b0;
      ch_done_id  <= '0;
      cur_ch      <= '0;
      rr_ptr      <= '0;
    end else begin
      ch_done <= 1'b0;
      if (load_go) begin
        dac_add_in  <= ADDR_BASE + 5'(pick_idx);
        dac_data_in <= tbl[pick_idx];
        cur_ch      <= pick_idx;
      end
      if (done_go) begin
        ch_done    <= 1'b1;
        ch_done_id <= cur_ch;
        rr_ptr     <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
      end
    end
  end

  // Refresh counter: free-runs while enabled, held at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ref_cnt <= '0;
    else if (!refresh_en)   ref_cnt <= '0;
    else if (ref_hit)       ref_cnt <= '0;
    else                    ref_cnt <= ref_cnt + 32'd1;
  end

  // Watchdog counter: restarts on WAIT entry, saturates past the trip point
  // so fault is raised once per stall and fault_clr can take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  wd_cnt <= '0;
    else if (load_go)                         wd_cnt <= '0;
    else if (state == WAIT && wd_cnt != TIMEOUT) wd_cnt <= wd_cnt + 32'd1;
  end

  // Sticky fault flag; a trip in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            fault <= 1'b0;
    else if (wd_hit)    fault <= 1'b1;
    else if (fault_clr) fault <= 1'b0;
  end

endmodule
